// File: rtl/wr_sl_responder_pkg.sv
// rtl/wr_sl_responder_pkg.sv - shared types and constants for the write-slave responder
package wr_sl_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/wr_sl_mem.sv
// rtl/wr_sl_mem.sv - word storage with one byte-enabled synchronous write port and one combinational read port
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (clears every word)
//   i_we, i_widx        write enable and word index
//   i_wbe, i_wdata      per-byte write enables and write data
//   i_ridx, o_rdata     combinational read index and data
module wr_sl_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_widx,
  input  logic [DATA_W/8-1:0]      i_wbe,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_ridx,
  output logic [DATA_W-1:0]        o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/wr_sl_responder.sv
// rtl/wr_sl_responder.sv - single-outstanding write-slave responder (AW/W/B channels) over small word storage
//
// Ports:
//   ACLK, ARESET                          clock, synchronous active-high reset
//   AWVALID/AWREADY/AWADDR/AWLEN/AWBURST  write-address channel
//   WVALID/WREADY/WDATA/WSTRB/WLAST       write-data channel
//   BVALID/BREADY/BRESP                   write-response channel
//   dbg_idx, dbg_data                     combinational storage read
// Build option: WR_SL_RESPONDER_STRB_EN - honour WSTRB byte lanes (otherwise full-word writes).
module wr_sl_responder
  import wr_sl_responder_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              AWADDR,
  input  logic [7:0]               AWLEN,
  input  logic [1:0]               AWBURST,
  input  logic                     WVALID,
  output logic                     WREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [DATA_W/8-1:0]      WSTRB,
  input  logic                     WLAST,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [1:0]               BRESP,
  input  logic [$clog2(DEPTH)-1:0] dbg_idx,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;
  logic [7:0]  r_beat;
  logic        r_err;

  logic              w_beat;
  logic              w_last;
  logic [32:0]       w_addr;
  logic [32:0]       w_lo;
  logic [32:0]       w_hi;
  logic [32:0]       w_off;
  logic              w_ok;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W/8-1:0] w_wbe;

  // Address math is done in 33 bits so a burst running past 4 GiB cannot
  // wrap back into the storage window.
  assign w_addr = {1'b0, r_addr} + {23'd0, r_beat, 2'b00};
  assign w_lo   = {1'b0, BASE_ADDR};
  assign w_hi   = w_lo + 33'(4 * DEPTH);
  assign w_off  = w_addr - w_lo;
  assign w_idx  = IDX_W'(w_off >> 2);
  assign w_ok   = (r_burst == BURST_INCR) && (w_addr >= w_lo) && (w_addr < w_hi);

  assign w_beat = WVALID && WREADY;
  assign w_last = (r_beat == r_len);

`ifdef WR_SL_RESPONDER_STRB_EN
  assign w_wbe = WSTRB;
`else
  logic w_unused_strb;
  assign w_unused_strb = ^WSTRB;
  assign w_wbe = '1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    BRESP       = RESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        WREADY = 1'b1;
        // Beat count, not WLAST, decides when the burst ends.
        if (WVALID && w_last) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        BVALID = 1'b1;
        BRESP  = r_err ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && AWVALID) begin
        r_addr  <= AWADDR;
        r_len   <= AWLEN;
        r_burst <= AWBURST;
        r_beat  <= '0;
        r_err   <= 1'b0;
      end
      if (w_beat) begin
        r_beat <= r_beat + 8'd1;
        if (!w_ok || (WLAST != w_last)) r_err <= 1'b1;
      end
    end
  end

  wr_sl_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_we    (w_beat && w_ok),
    .i_widx  (w_idx),
    .i_wbe   (w_wbe),
    .i_wdata (WDATA),
    .i_ridx  (dbg_idx),
    .o_rdata (dbg_data)
  );

endmodule

// File: tb/tb_wr_sl_responder.sv
// tb/tb_wr_sl_responder.sv - directed self-checking bench for wr_sl_responder
`timescale 1ns/1ps
module tb_wr_sl_responder;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  wr_sl_responder #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWBURST  (AWBURST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [31:0] exp);
    @(negedge ACLK);
    dbg_idx = 4'(idx);
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge ACLK);
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!AWREADY) check("aw_timeout", 32'd0, 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  // Starts and ends on a falling edge so back-to-back beats have no gap.
  task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    n = 0;
    while (!WREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!WREADY) check("w_timeout", 32'd0, 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic [1:0] exp, input int hold);
    int n;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_bvalid"}, 32'(BVALID), 32'd1);
      check({tag, "_hold_bresp"}, 32'(BRESP), 32'(exp));
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(BRESP), 32'(exp));
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    check({tag, "_awready_after"}, 32'(AWREADY), 32'd1);
    check({tag, "_bvalid_after"}, 32'(BVALID), 32'd0);
  endtask

  logic [31:0] exp_strb;

  initial begin
    ARESET = 1'b1;
    AWVALID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0;
    BREADY = 0; dbg_idx = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;

    check("rst_awready", 32'(AWREADY), 32'd1);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_bresp", 32'(BRESP), 32'd0);
    rd_chk("rst_word0", 0, 32'd0);

    // Single beat, response one cycle after the beat.
    aw(BASE + 32'd8, 8'd0, 2'b01);
    check("single_bvalid_pre", 32'(BVALID), 32'd0);
    wbeat(32'hDEADBEEF, 4'hF, 1'b1);
    check("single_latency", 32'(BVALID), 32'd1);
    wait_resp("single", 2'b00, 0);
    rd_chk("single_word2", 2, 32'hDEADBEEF);

    // 4-beat INCR with BREADY low for 3 cycles.
    aw(BASE, 8'd3, 2'b01);
    for (int i = 1; i <= 4; i++) wbeat(32'(i), 4'hF, i == 4);
    wait_resp("burst4", 2'b00, 3);
    for (int i = 0; i < 4; i++) rd_chk("burst4_word", i, 32'(i + 1));

    // Runs off the top of storage.
    aw(BASE + 32'(4 * (DEPTH - 1)), 8'd1, 2'b01);
    wbeat(32'hA5A5_0001, 4'hF, 1'b0);
    wbeat(32'hA5A5_0002, 4'hF, 1'b1);
    wait_resp("edge", 2'b10, 0);
    rd_chk("edge_word15", DEPTH - 1, 32'hA5A5_0001);
    rd_chk("edge_word0", 0, 32'd1);

    // FIXED burst type is rejected.
    aw(BASE + 32'd20, 8'd0, 2'b00);
    wbeat(32'hFFFF_FFFF, 4'hF, 1'b1);
    wait_resp("fixed", 2'b10, 0);
    rd_chk("fixed_word5", 5, 32'd0);

    // Address below the window.
    aw(BASE - 32'd4, 8'd0, 2'b01);
    wbeat(32'h1234_5678, 4'hF, 1'b1);
    wait_resp("below", 2'b10, 0);
    rd_chk("below_word0", 0, 32'd1);

    // Strobe handling.
    aw(BASE, 8'd0, 2'b01);
    wbeat(32'h11223344, 4'hF, 1'b1);
    wait_resp("strb_a", 2'b00, 0);
    aw(BASE, 8'd0, 2'b01);
    wbeat(32'hAABBCCDD, 4'b0101, 1'b1);
    wait_resp("strb_b", 2'b00, 0);
`ifdef WR_SL_RESPONDER_STRB_EN
    exp_strb = 32'h11BB33DD;
`else
    exp_strb = 32'hAABBCCDD;
`endif
    rd_chk("strb_word0", 0, exp_strb);

    // Early WLAST: flagged, but beat count still ends the burst.
    aw(BASE + 32'd24, 8'd1, 2'b01);
    wbeat(32'h66, 4'hF, 1'b1);
    check("early_last_no_resp", 32'(BVALID), 32'd0);
    wbeat(32'h77, 4'hF, 1'b1);
    wait_resp("early_last", 2'b10, 0);
    rd_chk("early_word6", 6, 32'h66);
    rd_chk("early_word7", 7, 32'h77);

    // WVALID while idle is ignored.
    @(negedge ACLK);
    WDATA = 32'h0BAD_0BAD; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("idle_w_wready", 32'(WREADY), 32'd0);
      check("idle_w_awready", 32'(AWREADY), 32'd1);
    end
    WVALID = 1'b0;
    rd_chk("idle_w_word0", 0, exp_strb);

    // Reset in the middle of a 4-beat burst.
    aw(BASE, 8'd3, 2'b01);
    wbeat(32'h9, 4'hF, 1'b0);
    wbeat(32'hA, 4'hF, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    check("midrst_awready", 32'(AWREADY), 32'd1);
    check("midrst_bvalid", 32'(BVALID), 32'd0);
    check("midrst_wready", 32'(WREADY), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_chk("midrst_word", i, 32'd0);
      check("midrst_no_bvalid", 32'(BVALID), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wr_sl_responder.md
WR_SL_RESPONDER -- requirements
Module: wr_sl_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of DATA_W-bit storage words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-004 SHALL have port ACLK, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have ports AWVALID in 1, AWREADY out 1, AWADDR in 32, AWLEN in 8, AWBURST in 2, forming the write-address channel.
REQ-007 SHALL have ports WVALID in 1, WREADY out 1, WDATA in DATA_W, WSTRB in DATA_W/8, WLAST in 1, forming the write-data channel.
REQ-008 SHALL have ports BVALID out 1, BREADY in 1, BRESP out 2, forming the write-response channel.
REQ-009 SHALL have ports dbg_idx in $clog2(DEPTH), dbg_data out DATA_W, a combinational storage read for the bench.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, DATA, RESP.
REQ-011 IDLE SHALL drive AWREADY=1, WREADY=0, BVALID=0; on AWVALID&AWREADY, SHALL capture AWADDR, AWLEN and AWBURST, clear the error flag and the beat counter, and enter DATA next cycle.
REQ-012 DATA SHALL drive WREADY=1 and AWREADY=0; each WVALID&WREADY is one beat.
REQ-013 A beat's address SHALL be captured AWADDR + 4*beat for INCR (AWBURST=2'b01).
REQ-014 A beat SHALL be written only when AWBURST=2'b01 and BASE_ADDR <= address < BASE_ADDR+4*DEPTH; otherwise SHALL be dropped and the sticky error flag set.
REQ-015 Address low two bits SHALL be ignored for indexing; index = (address-BASE_ADDR)>>2, with no wrap-around.
REQ-016 The last beat SHALL be the beat where beat counter == AWLEN; the FSM SHALL enter RESP the cycle after it.
REQ-017 If WLAST disagrees with REQ-016 on any beat, the error flag SHALL be set; the beat count still governs termination.
REQ-018 RESP SHALL drive BVALID=1, WREADY=0, and BRESP = 2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY); BRESP stable while BVALID=1.
REQ-019 On BVALID&BREADY, the FSM SHALL return to IDLE; AWREADY SHALL be 1 the following cycle.
REQ-020 Write-to-response latency SHALL be exactly 1 cycle after the last beat when BREADY is held 1.
REQ-021 WVALID in IDLE or RESP SHALL be ignored (no write, no state change).
REQ-022 Only one transaction SHALL be outstanding; no AW acceptance outside IDLE.

Reset
REQ-023 While ARESET=1 at a clock edge: FSM to IDLE, AWREADY=1 after the edge, WREADY=0, BVALID=0, BRESP=2'b00, counters and error flag 0, all storage words 0.
REQ-024 Reset mid-transaction SHALL abandon it without issuing a response.

Configuration
REQ-025 With macro WR_SL_RESPONDER_STRB_EN defined, a beat SHALL update only bytes whose WSTRB bit is 1.
REQ-026 Without WR_SL_RESPONDER_STRB_EN, WSTRB SHALL be ignored and every accepted beat SHALL write the full word.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef and BRESP constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, plus BURST_INCR=2'b01.
REQ-028 Storage SHALL be a sub-module wr_sl_mem (one synchronous byte-enabled write port, one combinational read port).

Verification
REQ-029 Single beat: AWADDR=BASE+8, AWLEN=0, WDATA=32'hDEADBEEF, WSTRB=4'hF, WLAST=1 -> BRESP=2'b00, dbg_idx=2 reads 32'hDEADBEEF.
REQ-030 4-beat INCR burst at BASE+0, data 1..4, BREADY held 0 for 3 cycles -> BVALID held with BRESP=2'b00 stable; words 0..3 = 1..4.
REQ-031 Burst AWADDR=BASE+4*(DEPTH-1), AWLEN=1 -> word DEPTH-1 written, second beat dropped, BRESP=2'b10, word 0 unchanged.
REQ-032 AWBURST=2'b00, AWLEN=0 -> no storage change, BRESP=2'b10.
REQ-033 STRB_EN build: word 0 = 32'h11223344, then WSTRB=4'b0101, WDATA=32'hAABBCCDD -> word 0 = 32'h11BB33DD; non-STRB build -> 32'hAABBCCDD.
REQ-034 ARESET asserted after 2 of 4 beats -> BVALID never asserts, AWREADY=1 next cycle, all words 0.
